// File: rtl/red_iterativa_core.sv
// red_iterativa_core: unsigned A>B prefix flags (N) and A==B (Z) over a K-cell chain, LSB to MSB
// RED_ITERATIVA_SERIAL_EN selects a single time-multiplexed cell (K-cycle latency, busy interlock)
module red_iterativa_core #(
   parameter int K = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [K-1:0] A,
   input  logic [K-1:0] B,
   output logic [K-1:0] N,
   output logic         Z,
   output logic         done
);
`ifdef RED_ITERATIVA_SERIAL_EN
   localparam int IW = K > 1 ? $clog2(K) : 1;
   logic [K-1:0]  a_q, b_q;
   logic [IW-1:0] idx;
   logic          busy, g_q, l_q, g_d, l_d, d;
   always_comb begin
      d   = a_q[idx] ^ b_q[idx];
      g_d = d ? a_q[idx] : g_q;
      l_d = d ? b_q[idx] : l_q;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         N    <= '0;
         Z    <= 1'b0;
         done <= 1'b0;
         busy <= 1'b0;
         idx  <= '0;
         g_q  <= 1'b0;
         l_q  <= 1'b0;
         a_q  <= '0;
         b_q  <= '0;
      end else begin
         done <= 1'b0;
         if (start && !busy) begin
            a_q  <= A;
            b_q  <= B;
            N    <= '0;
            g_q  <= 1'b0;
            l_q  <= 1'b0;
            idx  <= '0;
            busy <= 1'b1;
         end else if (busy) begin
            N[idx] <= g_d;
            g_q    <= g_d;
            l_q    <= l_d;
            idx    <= idx + 1'b1;
            if (idx == IW'(K - 1)) begin
               Z    <= ~g_d & ~l_d;
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
`else
   logic [K-1:0] n_d;
   logic         g, l;
   // a differing bit overrides everything below it; equal bits pass state up
   always_comb begin
      g   = 1'b0;
      l   = 1'b0;
      n_d = '0;
      for (int i = 0; i < K; i++) begin
         g      = (A[i] ^ B[i]) ? A[i] : g;
         l      = (A[i] ^ B[i]) ? B[i] : l;
         n_d[i] = g;
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         N    <= '0;
         Z    <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= start;
         if (start) begin
            N <= n_d;
            Z <= ~g & ~l;
         end
      end
`endif
endmodule

// File: tb/tb_red_iterativa_core.sv
// tb_red_iterativa_core: scoreboard bench for K=1/4/8 instances; expected {Z,N} from a masked-compare model
module tb_red_iterativa_core;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       s1 = 1'b0, s4 = 1'b0, s8 = 1'b0;
   logic [0:0] a1 = '0, b1 = '0, n1;
   logic [3:0] a4 = '0, b4 = '0, n4;
   logic [7:0] a8 = '0, b8 = '0, n8;
   logic       z1, z4, z8, d1, d4, d8;
   logic [8:0] q[$];
   int         checks = 0, errors = 0;

   always #5 clk = ~clk;

   red_iterativa_core #(.K(1)) u1 (.clk(clk), .rst_n(rst_n), .start(s1), .A(a1), .B(b1), .N(n1), .Z(z1), .done(d1));
   red_iterativa_core #(.K(4)) u4 (.clk(clk), .rst_n(rst_n), .start(s4), .A(a4), .B(b4), .N(n4), .Z(z4), .done(d4));
   red_iterativa_core #(.K(8)) u8 (.clk(clk), .rst_n(rst_n), .start(s8), .A(a8), .B(b8), .N(n8), .Z(z8), .done(d8));

   function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input int w);
      logic [8:0] r = '0;
      logic [7:0] m;
      for (int i = 0; i < w; i++) begin
         m    = 8'((16'd2 << i) - 1);
         r[i] = (a & m) > (b & m);
      end
      m    = 8'((16'd1 << w) - 1);
      r[8] = (a & m) == (b & m);
      return r;
   endfunction

   function automatic logic [8:0] obs(input int w);
      return w == 1 ? {z1, 7'b0, n1} : w == 4 ? {z4, 4'b0, n4} : {z8, n8};
   endfunction

   function automatic logic dn(input int w);
      return w == 1 ? d1 : w == 4 ? d4 : d8;
   endfunction

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic drive(input int w, input logic [7:0] a, input logic [7:0] b, input logic s);
      if (w == 1) begin a1 = a[0]; b1 = b[0]; s1 = s; end
      else if (w == 4) begin a4 = a[3:0]; b4 = b[3:0]; s4 = s; end
      else begin a8 = a; b8 = b; s8 = s; end
   endtask

   // operands are scrambled right after the start edge to prove they were captured
   task automatic run(input int w, input logic [7:0] a, input logic [7:0] b, input string tag);
      int c = 0;
      @(negedge clk);
      drive(w, a, b, 1'b1);
      q.push_back(model(a, b, w));
      @(negedge clk);
      drive(w, 8'($urandom), 8'($urandom), 1'b0);
      while (!dn(w) && c < 20) begin
         @(negedge clk);
         c++;
      end
      chk({tag, "_done_seen"}, 32'(c < 20), 32'd1);
      chk(tag, 32'(obs(w)), 32'(q.pop_front()));
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(dn(w)), 32'd0);
   endtask

   initial begin
      #2;
      chk("rst_n4", 32'(n4), 32'd0);
      chk("rst_z4", 32'(z4), 32'd0);
      chk("rst_done4", 32'(d4), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run(4, 8'h01, 8'h00, "dom_lsb");
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_n", 32'(n4), 32'd0);
      chk("async_rst_z", 32'(z4), 32'd0);
      chk("async_rst_done", 32'(d4), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run(4, 8'h0f, 8'h00, "all_g");
      run(4, 8'h0a, 8'h09, "mixed");
      run(4, 8'h06, 8'h06, "equal");
      run(4, 8'h00, 8'h0f, "all_l");
      run(4, 8'h01, 8'h00, "lsb_only");
      run(4, 8'h08, 8'h07, "capture");
`ifdef RED_ITERATIVA_SERIAL_EN
      begin
         int seen = 0;
         @(negedge clk);
         drive(4, 8'h0a, 8'h09, 1'b1);
         @(negedge clk);
         drive(4, 8'h00, 8'h00, 1'b0);
         @(negedge clk);
         drive(4, 8'h00, 8'h0f, 1'b1);
         @(negedge clk);
         drive(4, 8'h00, 8'h0f, 1'b0);
         for (int i = 0; i < 8; i++) begin
            if (d4) begin
               seen++;
               chk("busy_ignored_result", 32'({z4, n4}), 32'h0e);
            end
            @(negedge clk);
         end
         chk("busy_single_done", 32'(seen), 32'd1);
         seen = 0;
         drive(4, 8'h0f, 8'h00, 1'b1);
         @(negedge clk);
         drive(4, 8'h0f, 8'h00, 1'b0);
         @(negedge clk);
         #2 rst_n = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         for (int i = 0; i < 8; i++) begin
            seen += int'(d4);
            @(negedge clk);
         end
         chk("abort_no_done", 32'(seen), 32'd0);
         chk("abort_outputs", 32'({z4, n4}), 32'd0);
      end
`endif
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            run(4, 8'(a), 8'(b), "sweep4");
      for (int a = 0; a < 2; a++)
         for (int b = 0; b < 2; b++)
            run(1, 8'(a), 8'(b), "sweep1");
      run(8, 8'h80, 8'h7f, "k8_msb");
      run(8, 8'h5a, 8'h5a, "k8_eq");
      run(8, 8'h00, 8'hff, "k8_less");
      for (int i = 0; i < 30; i++)
         run(8, 8'($urandom), 8'($urandom), "k8_rand");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
